// File: rtl/irq_ctrl_pkg.sv
// irq_ctrl_pkg: shared FSM states, config register map and fixed-priority encoder
package irq_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        ACTIVE = 2'd2
    } irq_state_e;

    localparam logic [1:0] CFG_ENABLE  = 2'd0;
    localparam logic [1:0] CFG_MODE    = 2'd1;
    localparam logic [1:0] CFG_PENDING = 2'd2;
    localparam logic [1:0] CFG_STATUS  = 2'd3;

    localparam int STATUS_STATE_MSB = 31;
    localparam int STATUS_STATE_LSB = 30;

    // Lowest set index wins; returns 0 when nothing is set.
    function automatic logic [4:0] prio_enc(input logic [31:0] v);
        prio_enc = '0;
        for (int i = 31; i >= 0; i--)
            if (v[i]) prio_enc = 5'(i);
    endfunction

endpackage

// File: rtl/irq_sync.sv
// irq_sync: multi-stage synchroniser for one interrupt line plus rising-edge detect
module irq_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic irq_in,
    output logic sync,
    output logic rise
);

    logic [SYNC_STAGES-1:0] ff_q;
    logic                   sync_d_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ff_q     <= '0;
            sync_d_q <= 1'b0;
        end else begin
            ff_q     <= {ff_q[SYNC_STAGES-2:0], irq_in};
            sync_d_q <= ff_q[SYNC_STAGES-1];
        end
    end

    assign sync = ff_q[SYNC_STAGES-1];
    assign rise = sync & ~sync_d_q;

endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: NUM_IRQ-channel level/edge interrupt controller presenting one
// fixed-priority request at a time to the CSR file via req/ack/done.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter  int NUM_IRQ     = 8,
    parameter  int SYNC_STAGES = 2,
    localparam int IDW         = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               global_ie,
    input  logic               cfg_we,
    input  logic [1:0]         cfg_addr,
    input  logic [31:0]        cfg_wdata,
    output logic [31:0]        cfg_rdata,
    output logic               irq_req,
    output logic [IDW-1:0]     irq_id,
    input  logic               irq_ack,
    input  logic               irq_done
);

    logic [NUM_IRQ-1:0] sync, rise, pend, elig, w1c, ack_clr;
    logic [NUM_IRQ-1:0] en_q, en_d, mode_q, mode_d, ep_q, ep_d;
    irq_state_e         state_q, state_d;
    logic [IDW-1:0]     id_q, id_d;
    logic               req_q, req_d;
    logic [31:0]        elig_w, status;
    logic [4:0]         top_id;
    logic               unused;

    for (genvar i = 0; i < NUM_IRQ; i++) begin : g_sync
        irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk    (clk),
            .reset  (reset),
            .irq_in (irq_in[i]),
            .sync   (sync[i]),
            .rise   (rise[i])
        );
    end

    // Level channels track the synchronised line; only edge channels latch.
    assign pend    = (mode_q & ep_q) | (~mode_q & sync);
    assign elig    = pend & en_q;
    assign elig_w  = 32'(elig);
    assign top_id  = prio_enc(elig_w);
    assign en_d    = (cfg_we && cfg_addr == CFG_ENABLE) ? cfg_wdata[NUM_IRQ-1:0] : en_q;
    assign mode_d  = (cfg_we && cfg_addr == CFG_MODE) ? cfg_wdata[NUM_IRQ-1:0] : mode_q;
    assign w1c     = (cfg_we && cfg_addr == CFG_PENDING) ? cfg_wdata[NUM_IRQ-1:0] : '0;
    assign ack_clr = (state_q == REQ && irq_ack) ? (NUM_IRQ'(1) << id_q) : '0;
    assign ep_d    = mode_q & (rise | (ep_q & ~(w1c | ack_clr)));
    assign unused  = &{1'b0, cfg_wdata, top_id};

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        req_d   = req_q;
        case (state_q)
            IDLE: if (global_ie && |elig) begin
                state_d = REQ;
                id_d    = top_id[IDW-1:0];
                req_d   = 1'b1;
            end
            // Ack takes priority over a simultaneous withdraw.
            REQ: if (irq_ack) begin
                state_d = ACTIVE;
                req_d   = 1'b0;
            end else if (!elig_w[5'(id_q)] || !global_ie) begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
            ACTIVE: if (irq_done) state_d = IDLE;
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            id_q    <= '0;
            req_q   <= 1'b0;
            en_q    <= '0;
            mode_q  <= '0;
            ep_q    <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            req_q   <= req_d;
            en_q    <= en_d;
            mode_q  <= mode_d;
            ep_q    <= ep_d;
        end
    end

    always_comb begin
        status                                    = '0;
        status[STATUS_STATE_MSB:STATUS_STATE_LSB] = state_q;
        status[IDW-1:0]                           = id_q;
    end

    assign cfg_rdata = (cfg_addr == CFG_ENABLE)  ? 32'(en_q)   :
                       (cfg_addr == CFG_MODE)    ? 32'(mode_q) :
                       (cfg_addr == CFG_PENDING) ? 32'(pend)   : status;
    assign irq_req   = req_q;
    assign irq_id    = id_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: randomized and directed checks of irq_ctrl against a cycle-level
// behavioural model; extra NUM_IRQ=1 and NUM_IRQ=32 instances cover the width extremes.
module tb_irq_ctrl;

    localparam int N = 8;
    localparam int S = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [N-1:0] irq_in = '0;
    logic        global_ie = 1'b0, cfg_we = 1'b0, irq_ack = 1'b0, irq_done = 1'b0;
    logic [1:0]  cfg_addr = '0;
    logic [31:0] cfg_wdata = '0, cfg_rdata;
    logic        irq_req;
    logic [2:0]  irq_id;

    logic        r1_in = 1'b0, r1_ie = 1'b0, r1_we = 1'b0, r1_ack = 1'b0, r1_done = 1'b0, r1_req;
    logic [1:0]  r1_addr = '0;
    logic [31:0] r1_wd = '0, r1_rd;
    logic [0:0]  r1_id;
    logic [31:0] r32_in = '0, r32_wd = '0, r32_rd;
    logic        r32_ie = 1'b0, r32_we = 1'b0, r32_ack = 1'b0, r32_done = 1'b0, r32_req;
    logic [1:0]  r32_addr = '0;
    logic [4:0]  r32_id;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    irq_ctrl #(.NUM_IRQ(N), .SYNC_STAGES(S)) dut (
        .clk(clk), .reset(reset), .irq_in(irq_in), .global_ie(global_ie),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
        .irq_req(irq_req), .irq_id(irq_id), .irq_ack(irq_ack), .irq_done(irq_done)
    );

    irq_ctrl #(.NUM_IRQ(1)) dut1 (
        .clk(clk), .reset(reset), .irq_in(r1_in), .global_ie(r1_ie),
        .cfg_we(r1_we), .cfg_addr(r1_addr), .cfg_wdata(r1_wd), .cfg_rdata(r1_rd),
        .irq_req(r1_req), .irq_id(r1_id), .irq_ack(r1_ack), .irq_done(r1_done)
    );

    irq_ctrl #(.NUM_IRQ(32)) dut32 (
        .clk(clk), .reset(reset), .irq_in(r32_in), .global_ie(r32_ie),
        .cfg_we(r32_we), .cfg_addr(r32_addr), .cfg_wdata(r32_wd), .cfg_rdata(r32_rd),
        .irq_req(r32_req), .irq_id(r32_id), .irq_ack(r32_ack), .irq_done(r32_done)
    );

    // Reference model state: raw input history (h[0] = most recent sample),
    // config registers, latched edge pendings, and handshake state 0/1/2.
    logic [N-1:0] h [0:S];
    logic [N-1:0] m_en, m_mode, m_ep;
    int           m_state;
    logic [2:0]   m_id;
    logic         m_req;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [N-1:0] m_pend();
        logic [N-1:0] p;
        for (int i = 0; i < N; i++) p[i] = m_mode[i] ? m_ep[i] : h[S-1][i];
        return p;
    endfunction

    function automatic logic [31:0] m_rd(input logic [1:0] a);
        logic [31:0] v;
        v = '0;
        case (a)
            2'd0: v = 32'(m_en);
            2'd1: v = 32'(m_mode);
            2'd2: v = 32'(m_pend());
            default: begin
                v[31:30] = 2'(m_state);
                v[2:0]   = m_id;
            end
        endcase
        return v;
    endfunction

    task automatic m_clear();
        for (int k = 0; k <= S; k++) h[k] = '0;
        m_en = '0; m_mode = '0; m_ep = '0;
        m_state = 0; m_id = '0; m_req = 1'b0;
    endtask

    // One clock: predict from pre-edge state and inputs, advance, compare.
    task automatic tick();
        logic [N-1:0] s, rise, elig, clr, ep_n, en_n, mode_n, din;
        int           st_n, top;
        logic [2:0]   id_n;
        logic         req_n;
        s    = h[S-1];
        rise = s & ~h[S];
        elig = m_pend() & m_en;
        clr  = (cfg_we && cfg_addr == 2'd2) ? cfg_wdata[N-1:0] : '0;
        if (m_state == 1 && irq_ack) clr[m_id] = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (!m_mode[i])   ep_n[i] = 1'b0;
            else if (rise[i]) ep_n[i] = 1'b1;
            else if (clr[i])  ep_n[i] = 1'b0;
            else              ep_n[i] = m_ep[i];
        end
        en_n   = (cfg_we && cfg_addr == 2'd0) ? cfg_wdata[N-1:0] : m_en;
        mode_n = (cfg_we && cfg_addr == 2'd1) ? cfg_wdata[N-1:0] : m_mode;
        top = -1;
        for (int i = N - 1; i >= 0; i--) if (elig[i]) top = i;
        st_n = m_state; id_n = m_id; req_n = m_req;
        if (m_state == 0) begin
            if (global_ie && top >= 0) begin st_n = 1; id_n = 3'(top); req_n = 1'b1; end
        end else if (m_state == 1) begin
            if (irq_ack) begin st_n = 2; req_n = 1'b0; end
            else if (!elig[m_id] || !global_ie) begin st_n = 0; req_n = 1'b0; end
        end else if (irq_done) st_n = 0;
        din = irq_in;
        @(posedge clk);
        for (int k = S; k > 0; k--) h[k] = h[k-1];
        h[0] = din;
        m_en = en_n; m_mode = mode_n; m_ep = ep_n;
        m_state = st_n; m_id = id_n; m_req = req_n;
        #1;
        check("req", 32'(irq_req), 32'(m_req));
        check("id", 32'(irq_id), 32'(m_id));
        check("rdata", cfg_rdata, m_rd(cfg_addr));
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] v);
        cfg_addr = a;
        #1;
        v = cfg_rdata;
    endtask

    task automatic pulse_ack();
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    endtask

    task automatic pulse_done();
        irq_done = 1'b1; tick(); irq_done = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        logic [31:0] v;
        #2 reset = 1'b1;
        irq_in = '0; irq_ack = 1'b0; irq_done = 1'b0; cfg_we = 1'b0;
        #1;
        check({tag, "_req"}, 32'(irq_req), 32'd0);
        check({tag, "_id"}, 32'(irq_id), 32'd0);
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), v);
            check($sformatf("%s_rd%0d", tag, a), v, 32'd0);
        end
        m_clear();
        @(negedge clk) reset = 1'b0;
    endtask

    initial begin
        logic [31:0] v;
        m_clear();
        @(posedge clk); #1;
        do_reset("rst0");
        global_ie = 1'b1;

        // Edge channel 3: request exactly 4 edges after a 1-cycle pulse.
        wr(2'd0, 32'h08);
        wr(2'd1, 32'h08);
        irq_in[3] = 1'b1; tick(); irq_in[3] = 1'b0;
        tick(); tick();
        check("t1_early", 32'(irq_req), 32'd0);
        tick();
        check("t1_req", 32'(irq_req), 32'd1);
        check("t1_id", 32'(irq_id), 32'd3);
        pulse_ack();
        rd(2'd2, v); check("t1_pend", v, 32'd0);
        rd(2'd3, v); check("t1_st", v >> 30, 32'd2);
        pulse_done();
        rd(2'd3, v); check("t1_idle", v, 32'd3);

        // Channels 2 and 5 pending together: 2 first, then 5.
        wr(2'd0, 32'h24);
        wr(2'd1, 32'h24);
        irq_in = 8'h24; tick(); irq_in = '0;
        repeat (3) tick();
        check("t2_id2", 32'(irq_id), 32'd2);
        pulse_ack();
        pulse_done();
        tick();
        check("t2_req5", 32'(irq_req), 32'd1);
        check("t2_id5", 32'(irq_id), 32'd5);
        pulse_ack();
        pulse_done();

        // Level channel 6: re-request while held, withdraw on deassert.
        wr(2'd0, 32'h40);
        irq_in[6] = 1'b1;
        repeat (3) tick();
        check("t3_id6", 32'(irq_id), 32'd6);
        pulse_ack();
        pulse_done();
        tick();
        check("t3_rereq", 32'(irq_req), 32'd1);
        irq_in[6] = 1'b0;
        repeat (3) tick();
        check("t3_wdraw", 32'(irq_req), 32'd0);

        // global_ie gating, then W1C colliding with a new rise.
        global_ie = 1'b0;
        wr(2'd0, 32'h01);
        wr(2'd1, 32'h01);
        irq_in[0] = 1'b1; tick(); irq_in[0] = 1'b0;
        repeat (4) tick();
        check("t4_noreq", 32'(irq_req), 32'd0);
        global_ie = 1'b1;
        tick();
        check("t4_req", 32'(irq_req), 32'd1);
        irq_in[0] = 1'b1; tick(); irq_in[0] = 1'b0;
        tick();
        wr(2'd2, 32'h01);
        rd(2'd2, v); check("t4_setwins", v, 32'h01);
        pulse_ack();
        pulse_done();

        // Stray ack/done, then ack racing an ENABLE clear.
        global_ie = 1'b0;
        pulse_ack();
        rd(2'd3, v); check("t5_idle", v >> 30, 32'd0);
        global_ie = 1'b1;
        irq_in[0] = 1'b1; tick(); irq_in[0] = 1'b0;
        repeat (3) tick();
        pulse_done();
        rd(2'd3, v); check("t5_req", v >> 30, 32'd1);
        cfg_we = 1'b1; cfg_addr = 2'd0; cfg_wdata = '0; irq_ack = 1'b1;
        tick();
        cfg_we = 1'b0; irq_ack = 1'b0;
        rd(2'd3, v); check("t5_ackwins", v >> 30, 32'd2);
        pulse_done();

        // Reset while ACTIVE with pending 0xF0.
        wr(2'd0, 32'hF0);
        wr(2'd1, 32'hF0);
        irq_in = 8'hF0; tick(); irq_in = '0;
        repeat (3) tick();
        pulse_ack();
        irq_in = 8'h10; tick(); irq_in = '0;
        repeat (2) tick();
        rd(2'd2, v); check("t6_pend", v, 32'hF0);
        rd(2'd3, v); check("t6_act", v >> 30, 32'd2);
        do_reset("t6_rst");

        // Randomized traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            irq_in    = 8'($urandom & $urandom & $urandom);
            global_ie = ($urandom_range(7) != 0);
            cfg_we    = ($urandom_range(9) == 0);
            cfg_addr  = 2'($urandom_range(3));
            cfg_wdata = $urandom;
            irq_ack   = ($urandom_range(3) == 0);
            irq_done  = ($urandom_range(3) == 0);
            tick();
        end
        irq_in = '0; cfg_we = 1'b0; irq_ack = 1'b0; irq_done = 1'b0;

        // Width extremes: NUM_IRQ=32 reaches id 31, NUM_IRQ=1 uses id 0.
        r32_we = 1'b1; r32_addr = 2'd0; r32_wd = 32'h8000_0000;
        r1_we = 1'b1; r1_addr = 2'd0; r1_wd = 32'h1;
        @(posedge clk); #1;
        r32_we = 1'b0; r1_we = 1'b0;
        r32_in[31] = 1'b1; r1_in = 1'b1; r32_ie = 1'b1; r1_ie = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("n32_req", 32'(r32_req), 32'd1);
        check("n32_id", 32'(r32_id), 32'd31);
        check("n1_req", 32'(r1_req), 32'd1);
        check("n1_id", 32'(r1_id), 32'd0);
        r32_ack = 1'b1; r1_ack = 1'b1;
        @(posedge clk); #1;
        r32_ack = 1'b0; r1_ack = 1'b0; r32_addr = 2'd3; r1_addr = 2'd3;
        #1;
        check("n32_st", r32_rd, 32'h8000_001F);
        check("n1_st", r1_rd, 32'h8000_0000);
        reset = 1'b1;
        #1;
        check("n32_rreq", 32'(r32_req), 32'd0);
        check("n32_rid", 32'(r32_id), 32'd0);
        check("n32_rst", r32_rd, 32'd0);
        check("n1_rreq", 32'(r1_req), 32'd0);
        check("n1_rst", r1_rd, 32'd0);
        r32_addr = 2'd2;
        #1;
        check("n32_rpend", r32_rd, 32'd0);
        @(negedge clk) reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
